// File: rtl/gpio_hash_bridge.sv
// gpio_hash_bridge: byte-serial pin front end feeding an external hash core.
// Streams message bytes to the core, captures the digest, returns it in words.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   din/valid/last/abort  message byte stream from the pins, abort request
//   dready                consumer accepts dout when dvalid&dready
//   busy                  operation in progress
//   dout/dvalid/dlast     digest word, valid, final-word marker
//   err                   sticky error (overrun, stray core_done, watchdog)
//   core_start/data/valid/last  strobes into the hash core
//   core_hash/core_done   digest and digest-ready pulse from the core
// Optional feature: define GPIO_HASH_TIMEOUT_EN for the WAIT-state watchdog.
module gpio_hash_bridge #(
  parameter int DIGEST_BITS = 256,
  parameter int OUT_W       = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             din,
  input  logic                   valid,
  input  logic                   last,
  input  logic                   abort,
  input  logic                   dready,
  output logic                   busy,
  output logic [OUT_W-1:0]       dout,
  output logic                   dvalid,
  output logic                   dlast,
  output logic                   err,
  output logic                   core_start,
  output logic [7:0]             core_data,
  output logic                   core_valid,
  output logic                   core_last,
  input  logic [DIGEST_BITS-1:0] core_hash,
  input  logic                   core_done
);

  localparam int NW = DIGEST_BITS / OUT_W;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LASTW = CW'(NW - 1);

  if (OUT_W < 1 || OUT_W > DIGEST_BITS) begin : g_bad_outw
    $error("OUT_W must be in 1..DIGEST_BITS");
  end
  if (DIGEST_BITS % OUT_W != 0) begin : g_bad_mult
    $error("DIGEST_BITS must be a multiple of OUT_W");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_DUMP
  } state_t;

  state_t                 state;
  logic [DIGEST_BITS-1:0] sh;
  logic [CW-1:0]          cnt;
  logic                   tmo;

  // The emitting end of the shift register is the output word.
  if (MSB_FIRST) begin : g_msb
    assign dout = sh[DIGEST_BITS-1 -: OUT_W];
  end else begin : g_lsb
    assign dout = sh[OUT_W-1:0];
  end

`ifdef GPIO_HASH_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tcnt;

  // Held at zero outside WAIT, so it restarts on every entry.
  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign tmo = (tcnt == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sh         <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      dvalid     <= 1'b0;
      dlast      <= 1'b0;
      err        <= 1'b0;
      core_start <= 1'b0;
      core_data  <= '0;
      core_valid <= 1'b0;
      core_last  <= 1'b0;
    end else begin
      core_start <= 1'b0;
      core_valid <= 1'b0;
      core_last  <= 1'b0;
      if (abort && state != S_IDLE) begin
        state  <= S_IDLE;
        busy   <= 1'b0;
        dvalid <= 1'b0;
        dlast  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (core_done) err <= 1'b1;
            if (valid) begin
              core_start <= 1'b1;
              core_valid <= 1'b1;
              core_data  <= din;
              core_last  <= last;
              busy       <= 1'b1;
              err        <= 1'b0;
              state      <= last ? S_WAIT : S_FEED;
            end
          end
          S_FEED: begin
            if (core_done) err <= 1'b1;
            if (valid) begin
              core_valid <= 1'b1;
              core_data  <= din;
              core_last  <= last;
              if (last) state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (valid) err <= 1'b1;
            if (core_done) begin
              sh     <= core_hash;
              cnt    <= '0;
              dvalid <= 1'b1;
              dlast  <= (LASTW == '0);
              state  <= S_DUMP;
            end else if (tmo) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          S_DUMP: begin
            if (valid || core_done) err <= 1'b1;
            if (dvalid && dready) begin
              sh  <= MSB_FIRST ? (sh << OUT_W) : (sh >> OUT_W);
              cnt <= cnt + CW'(1);
              if (cnt == LASTW) begin
                dvalid <= 1'b0;
                dlast  <= 1'b0;
                busy   <= 1'b0;
                state  <= S_IDLE;
              end else begin
                dlast <= ((cnt + CW'(1)) == LASTW);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_hash_bridge.sv
// tb_gpio_hash_bridge: scoreboard bench for gpio_hash_bridge.
// Two instances: default (8-bit MSB first) and 32-bit LSB first.
module tb_gpio_hash_bridge;

  localparam logic [255:0] SHA_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] H2 =
    256'h01234567_89abcdef_fedcba98_76543210_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  localparam logic [255:0] H3 =
    256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
  localparam logic [255:0] H5 =
    256'hdeadbeef_cafef00d_a5a5a5a5_5a5a5a5a_00ff00ff_ff00ff00_13579bdf_2468ace0;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } wexp_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       s;
  } cexp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   din;
  logic         valid, last, abort, dready;
  logic [255:0] core_hash;
  logic         core_done;

  logic         busy1, dvalid1, dlast1, err1, cs1, cv1, cl1;
  logic [7:0]   dout1, cd1;
  logic         busy2, dvalid2, dlast2, err2, cs2, cv2, cl2;
  logic [31:0]  dout2;
  logic [7:0]   cd2;

  wexp_t q1[$], q2[$];
  cexp_t qc1[$], qc2[$];
  wexp_t e1, e2;
  cexp_t c1, c2;

  int checks = 0;
  int failures = 0;
  int acc1 = 0, acc2 = 0;
  logic [7:0]  held1;
  logic [31:0] held2;
  logic        hl1, hl2;
  bit          st1 = 0, st2 = 0, pend1 = 0;

  always #5 clk = ~clk;

  gpio_hash_bridge #(
    .DIGEST_BITS(256), .OUT_W(8), .MSB_FIRST(1'b1), .TIMEOUT_CYC(16)
  ) u_dut1 (
    .clk(clk), .rst(rst), .din(din), .valid(valid), .last(last),
    .abort(abort), .dready(dready), .busy(busy1), .dout(dout1),
    .dvalid(dvalid1), .dlast(dlast1), .err(err1), .core_start(cs1),
    .core_data(cd1), .core_valid(cv1), .core_last(cl1),
    .core_hash(core_hash), .core_done(core_done)
  );

  gpio_hash_bridge #(
    .DIGEST_BITS(256), .OUT_W(32), .MSB_FIRST(1'b0), .TIMEOUT_CYC(16)
  ) u_dut2 (
    .clk(clk), .rst(rst), .din(din), .valid(valid), .last(last),
    .abort(abort), .dready(dready), .busy(busy2), .dout(dout2),
    .dvalid(dvalid2), .dlast(dlast2), .err(err2), .core_start(cs2),
    .core_data(cd2), .core_valid(cv2), .core_last(cl2),
    .core_hash(core_hash), .core_done(core_done)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Digest word monitor, instance 1.
  always @(negedge clk) begin
    if (pend1) begin
      chk("busy_fall1", {62'd0, busy1, dvalid1}, 64'd0);
      pend1 = 0;
    end
    if (!rst && dvalid1) begin
      if (!dready) begin
        if (st1) chk("hold1", {55'd0, dout1, dlast1}, {55'd0, held1, hl1});
        held1 = dout1;
        hl1   = dlast1;
        st1   = 1;
      end else begin
        st1 = 0;
        acc1++;
        if (q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_word1 act=%h exp=none", dout1);
        end else begin
          e1 = q1.pop_front();
          chk("word1", {55'd0, dout1, dlast1}, {55'd0, e1.d[7:0], e1.l});
          if (e1.l) pend1 = 1;
        end
      end
    end else begin
      st1 = 0;
    end
  end

  // Digest word monitor, instance 2.
  always @(negedge clk) begin
    if (!rst && dvalid2) begin
      if (!dready) begin
        if (st2) chk("hold2", {31'd0, dout2, dlast2}, {31'd0, held2, hl2});
        held2 = dout2;
        hl2   = dlast2;
        st2   = 1;
      end else begin
        st2 = 0;
        acc2++;
        if (q2.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_word2 act=%h exp=none", dout2);
        end else begin
          e2 = q2.pop_front();
          chk("word2", {31'd0, dout2, dlast2}, {31'd0, e2.d, e2.l});
        end
      end
    end else begin
      st2 = 0;
    end
  end

  // Core-side monitors.
  always @(negedge clk) begin
    if (!rst && (cv1 || cs1)) begin
      if (qc1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_core1 act=%h exp=none", {cd1, cl1, cs1});
      end else begin
        c1 = qc1.pop_front();
        chk("core1", {54'd0, cv1, cd1, cl1, cs1}, {54'd0, 1'b1, c1});
      end
    end
    if (!rst && (cv2 || cs2)) begin
      if (qc2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_core2 act=%h exp=none", {cd2, cl2, cs2});
      end else begin
        c2 = qc2.pop_front();
        chk("core2", {54'd0, cv2, cd2, cl2, cs2}, {54'd0, 1'b1, c2});
      end
    end
  end

  task automatic send(logic [7:0] b, logic l, bit fwd, bit st);
    din   = b;
    last  = l;
    valid = 1'b1;
    if (fwd) begin
      qc1.push_back({b, l, st});
      qc2.push_back({b, l, st});
    end
    tick();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic done(logic [255:0] h);
    core_hash = h;
    core_done = 1'b1;
    for (int i = 0; i < 32; i++)
      q1.push_back({24'd0, h[255-8*i -: 8], i == 31});
    for (int i = 0; i < 8; i++)
      q2.push_back({h[32*i +: 32], i == 7});
    tick();
    core_done = 1'b0;
    chk("dvalid_rise", {62'd0, dvalid1, dvalid2}, 64'd3);
  endtask

  task automatic wait_idle(int lim);
    int n = 0;
    while ((busy1 || busy2 || dvalid1 || dvalid2) && n < lim) begin
      tick();
      n++;
    end
    checks++;
    if (n >= lim) begin
      failures++;
      $display("FAIL idle_timeout act=%0d exp<%0d", n, lim);
    end
  endtask

  task automatic send_abc(bit st);
    send(8'h61, 1'b0, 1'b1, st);
    send(8'h62, 1'b0, 1'b1, 1'b0);
    send(8'h63, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k, b1, b2;
    rst = 1'b1;
    din = '0;
    valid = 1'b0;
    last = 1'b0;
    abort = 1'b0;
    dready = 1'b1;
    core_hash = '0;
    core_done = 1'b0;
    tick(3);
    chk("rst_out1", {41'd0, busy1, dvalid1, dlast1, err1, cs1, cv1, cl1,
                     cd1, dout1}, 64'd0);
    chk("rst_out2", {17'd0, busy2, dvalid2, dlast2, err2, cs2, cv2, cl2,
                     cd2, dout2}, 64'd0);
    rst = 1'b0;
    tick();

    // "abc" with the SHA-256 digest.
    send(8'h61, 1'b0, 1'b1, 1'b1);
    chk("first_fwd", {50'd0, busy1, cs1, cv1, cd1, busy2, cs2, cv2},
        {50'd0, 1'b1, 1'b1, 1'b1, 8'h61, 1'b1, 1'b1, 1'b1});
    send(8'h62, 1'b0, 1'b1, 1'b0);
    send(8'h63, 1'b1, 1'b1, 1'b0);
    tick(2);
    done(SHA_ABC);
    wait_idle(100);
    chk("q_drain_t1", 64'(q1.size() + q2.size()), 64'd0);

    // Single-byte message.
    send(8'h5a, 1'b1, 1'b1, 1'b1);
    tick();
    done(H2);
    wait_idle(100);

    // Backpressure 1,0,0,1.
    send_abc(1'b1);
    tick();
    b1 = acc1;
    b2 = acc2;
    done(H3);
    k = 0;
    while ((busy1 || busy2) && k < 400) begin
      dready = (k % 4 == 0) || (k % 4 == 3);
      tick();
      k++;
    end
    dready = 1'b1;
    wait_idle(20);
    chk("accepts1", 64'(acc1 - b1), 64'd32);
    chk("accepts2", 64'(acc2 - b2), 64'd8);

    // Abort mid-FEED with a simultaneous byte, then a fresh "abc".
    send(8'h11, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      send(8'h22 + 8'(i), 1'b0, 1'b1, 1'b0);
    abort = 1'b1;
    valid = 1'b1;
    din = 8'h66;
    tick();
    abort = 1'b0;
    valid = 1'b0;
    chk("abort_busy", {62'd0, busy1, busy2}, 64'd0);
    tick(2);
    send_abc(1'b1);
    tick();
    done(SHA_ABC);
    wait_idle(100);
    chk("abort_err", {62'd0, err1, err2}, 64'd0);

    // Overrun during WAIT.
    send(8'h77, 1'b1, 1'b1, 1'b1);
    send(8'h88, 1'b0, 1'b0, 1'b0);
    chk("overrun_err", {62'd0, err1, err2}, 64'd3);
    done(H5);
    wait_idle(100);
    chk("err_sticky", {62'd0, err1, err2}, 64'd3);
    send(8'h99, 1'b1, 1'b1, 1'b1);
    chk("err_clear", {62'd0, err1, err2}, 64'd0);
    done(H2);
    wait_idle(100);

    // Stray core_done in IDLE.
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("stray_done_err", {62'd0, err1, err2}, 64'd3);
    send(8'haa, 1'b1, 1'b1, 1'b1);
    chk("err_clear2", {62'd0, err1, err2}, 64'd0);
    done(H3);
    wait_idle(100);

    // Reset in the middle of DUMP.
    send(8'hbb, 1'b1, 1'b1, 1'b1);
    dready = 1'b0;
    done(SHA_ABC);
    tick(3);
    chk("dump_stall", {62'd0, dvalid1, dvalid2}, 64'd3);
    rst = 1'b1;
    tick();
    chk("rst_dump1", {41'd0, busy1, dvalid1, dlast1, err1, cs1, cv1, cl1,
                      cd1, dout1}, 64'd0);
    chk("rst_dump2", {17'd0, busy2, dvalid2, dlast2, err2, cs2, cv2, cl2,
                      cd2, dout2}, 64'd0);
    q1.delete();
    q2.delete();
    rst = 1'b0;
    dready = 1'b1;
    tick(2);

`ifdef GPIO_HASH_TIMEOUT_EN
    send(8'hcc, 1'b1, 1'b1, 1'b1);
    tick(15);
    chk("tmo_before", {60'd0, err1, busy1, err2, busy2}, 64'b0101);
    tick();
    chk("tmo_fire", {58'd0, err1, busy1, dvalid1, err2, busy2, dvalid2},
        64'b100100);
    tick(5);
    chk("tmo_nodump", {62'd0, dvalid1, dvalid2}, 64'd0);
`endif

    tick(5);
    chk("final_drain", 64'(q1.size() + q2.size() + qc1.size() + qc2.size()),
        64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
